// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: depth derivation from address width.
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned widthad);
    return 32'd1 << widthad;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 4
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [WIDTHAD-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTHAD-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int DEPTH = fifo_depth(WIDTHAD);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; flow control guarantees no word is read before it is written.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with programmable almost-full/empty levels, fill count,
// sticky overflow/underflow, synchronous flush and optional registered output.
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTHAD   = 4,
  parameter bit SHOWAHEAD = 1'b1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               CLR,
  input  logic [WIDTH-1:0]   D,
  input  logic               WR,
  input  logic               RD,
  input  logic [WIDTHAD:0]   AF_LVL,
  input  logic [WIDTHAD:0]   AE_LVL,
  output logic [WIDTH-1:0]   Q,
  output logic               QV,
  output logic [WIDTHAD:0]   CNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               AFULL,
  output logic               AEMPTY,
  output logic               OVF,
  output logic               UDF
);

  logic [WIDTHAD:0] wcnt, rcnt;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;

  // One extra pointer bit distinguishes full from empty without a separate counter.
  assign CNT    = wcnt - rcnt;
  assign FULL   = CNT[WIDTHAD];
  assign EMPTY  = (CNT == '0);
  assign AFULL  = (CNT >= AF_LVL);
  assign AEMPTY = (CNT <= AE_LVL);

  assign wr_ok = WR & ~FULL  & ~CLR;
  assign rd_ok = RD & ~EMPTY & ~CLR;

  fifo_ram #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) u_ram (
    .CLK   (CLK),
    .we    (wr_ok),
    .waddr (wcnt[WIDTHAD-1:0]),
    .wdata (D),
    .raddr (rcnt[WIDTHAD-1:0]),
    .rdata (rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt <= '0;
      rcnt <= '0;
      OVF  <= 1'b0;
      UDF  <= 1'b0;
    end else if (CLR) begin
      wcnt <= '0;
      rcnt <= '0;
      OVF  <= 1'b0;
      UDF  <= 1'b0;
    end else begin
      if (wr_ok)      wcnt <= wcnt + 1'b1;
      if (rd_ok)      rcnt <= rcnt + 1'b1;
      if (WR & FULL)  OVF  <= 1'b1;
      if (RD & EMPTY) UDF  <= 1'b1;
    end
  end

  generate
    if (SHOWAHEAD) begin : g_showahead
      assign Q  = rdata;
      assign QV = ~EMPTY;
    end else begin : g_registered
      logic [WIDTH-1:0] q_r;
      logic             qv_r;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          q_r  <= '0;
          qv_r <= 1'b0;
        end else if (CLR) begin
          qv_r <= 1'b0;
        end else begin
          qv_r <= rd_ok;
          if (rd_ok) q_r <= rdata;
        end
      end

      assign Q  = q_r;
      assign QV = qv_r;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_thresh.sv
// Self-checking bench: showahead and registered-output FIFOs driven in parallel
// and compared against a queue-based reference model.
module tb_fifo_thresh;

  localparam int W  = 8;
  localparam int AW = 2;
  localparam int DP = 4;

  logic          clk, rst_n, clr, wr, rd;
  logic [W-1:0]  d;
  logic [AW:0]   af_lvl, ae_lvl;

  logic [W-1:0]  q_a, q_b;
  logic          qv_a, qv_b;
  logic [AW:0]   cnt_a, cnt_b;
  logic          full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
  logic          full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;

  fifo_thresh #(.WIDTH(W), .WIDTHAD(AW), .SHOWAHEAD(1'b1)) dut_a (
    .CLK(clk), .nRST(rst_n), .CLR(clr), .D(d), .WR(wr), .RD(rd),
    .AF_LVL(af_lvl), .AE_LVL(ae_lvl), .Q(q_a), .QV(qv_a), .CNT(cnt_a),
    .FULL(full_a), .EMPTY(empty_a), .AFULL(afull_a), .AEMPTY(aempty_a),
    .OVF(ovf_a), .UDF(udf_a)
  );

  fifo_thresh #(.WIDTH(W), .WIDTHAD(AW), .SHOWAHEAD(1'b0)) dut_b (
    .CLK(clk), .nRST(rst_n), .CLR(clr), .D(d), .WR(wr), .RD(rd),
    .AF_LVL(af_lvl), .AE_LVL(ae_lvl), .Q(q_b), .QV(qv_b), .CNT(cnt_b),
    .FULL(full_b), .EMPTY(empty_b), .AFULL(afull_b), .AEMPTY(aempty_b),
    .OVF(ovf_b), .UDF(udf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, sticky flags, registered-mode output.
  logic [W-1:0] mq[$];
  logic         m_ovf, m_udf, m_qv;
  logic [W-1:0] m_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_qv  = 1'b0;
    m_q   = '0;
  endtask

  task automatic model_edge();
    bit was_full, was_empty;
    was_full  = (mq.size() == DP);
    was_empty = (mq.size() == 0);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_qv  = 1'b0;
    end else begin
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
      m_qv = rd && !was_empty;
      if (m_qv) m_q = mq.pop_front();
      if (wr && !was_full) mq.push_back(d);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = mq.size();
    check({ctx, ".cnt_a"},    32'(cnt_a),    32'(n));
    check({ctx, ".cnt_b"},    32'(cnt_b),    32'(n));
    check({ctx, ".full"},     32'(full_a),   32'(n == DP));
    check({ctx, ".empty"},    32'(empty_a),  32'(n == 0));
    check({ctx, ".afull"},    32'(afull_a),  32'(n >= int'(af_lvl)));
    check({ctx, ".aempty"},   32'(aempty_a), 32'(n <= int'(ae_lvl)));
    check({ctx, ".afull_b"},  32'(afull_b),  32'(n >= int'(af_lvl)));
    check({ctx, ".aempty_b"}, 32'(aempty_b), 32'(n <= int'(ae_lvl)));
    check({ctx, ".flags_b"},  32'({full_b, empty_b}), 32'({n == DP, n == 0}));
    check({ctx, ".ovf"},      32'({ovf_a, ovf_b}), 32'({m_ovf, m_ovf}));
    check({ctx, ".udf"},      32'({udf_a, udf_b}), 32'({m_udf, m_udf}));
    check({ctx, ".qv_a"},     32'(qv_a),     32'(n != 0));
    if (n != 0) check({ctx, ".q_a"}, 32'(q_a), 32'(mq[0]));
    check({ctx, ".qv_b"},     32'(qv_b),     32'(m_qv));
    check({ctx, ".q_b"},      32'(q_b),      32'(m_q));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input string ctx, input logic c, input logic w, input logic r,
                      input logic [W-1:0] dd);
    clr = c; wr = w; rd = r; d = dd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    clr = 1'b0; wr = 1'b0; rd = 1'b0; d = '0;
    af_lvl = '0; ae_lvl = 3'd1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.afull_lvl0", 32'(afull_a), 32'd1);
    af_lvl = 3'd3;
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst");

    // Fill to full, then overflow.
    step("fill1", 0, 1, 0, 8'h11);
    step("fill2", 0, 1, 0, 8'h22);
    step("fill3", 0, 1, 0, 8'h33);
    check("fill3.afull", 32'(afull_a), 32'd1);
    step("fill4", 0, 1, 0, 8'h44);
    check("fill4.cnt", 32'(cnt_a), 32'd4);
    check("fill4.full", 32'(full_a), 32'd1);
    step("ovf", 0, 1, 0, 8'h55);
    check("ovf.cnt", 32'(cnt_a), 32'd4);

    // Thresholds are live: moving AF_LVL changes AFULL with no clock edge.
    af_lvl = 3'd5;
    #1;
    check("afull_live_hi", 32'(afull_a), 32'd0);
    af_lvl = 3'd3;
    #1;
    check("afull_live_back", 32'(afull_a), 32'd1);

    // Drain in order, then underflow.
    check("drain.head", 32'(q_a), 32'h11);
    step("drain1", 0, 0, 1, 8'h00);
    step("drain2", 0, 0, 1, 8'h00);
    step("drain3", 0, 0, 1, 8'h00);
    check("drain3.aempty", 32'(aempty_a), 32'd1);
    step("drain4", 0, 0, 1, 8'h00);
    check("drain4.empty", 32'(empty_a), 32'd1);
    step("udf", 0, 0, 1, 8'h00);
    check("udf.flag", 32'(udf_a), 32'd1);
    step("clr1", 1, 0, 0, 8'h00);

    // Simultaneous WR&RD at CNT=2.
    step("wr_a", 0, 1, 0, 8'hA1);
    step("wr_b", 0, 1, 0, 8'hB2);
    step("wrrd2", 0, 1, 1, 8'hC3);
    check("wrrd2.cnt", 32'(cnt_a), 32'd2);
    step("rd_b", 0, 0, 1, 8'h00);
    step("rd_c", 0, 0, 1, 8'h00);

    // Simultaneous WR&RD at full, then flush with pending overflow and a write.
    for (int i = 0; i < DP; i++) step("refill", 0, 1, 0, 8'(8'h60 + i));
    step("wrrd4", 0, 1, 1, 8'hDD);
    check("wrrd4.cnt", 32'(cnt_a), 32'd3);
    check("wrrd4.ovf", 32'(ovf_a), 32'd1);
    step("clr_wr", 1, 1, 0, 8'hEE);
    check("clr.cnt", 32'(cnt_a), 32'd0);
    check("clr.ovf", 32'(ovf_a), 32'd0);
    step("after_clr_wr", 0, 1, 0, 8'h77);
    check("after_clr.q", 32'(q_a), 32'h77);
    step("after_clr_rd", 0, 0, 1, 8'h00);

    // Simultaneous WR&RD when empty.
    step("wrrd0", 0, 1, 1, 8'h5A);
    check("wrrd0.cnt", 32'(cnt_a), 32'd1);
    check("wrrd0.udf", 32'(udf_a), 32'd1);
    step("wrrd0_rd", 0, 0, 1, 8'h00);
    step("clr2", 1, 0, 0, 8'h00);

    // Registered-output read latency.
    step("sa0_wr", 0, 1, 0, 8'hA5);
    step("sa0_rd", 0, 0, 1, 8'h00);
    check("sa0.qv_n1", 32'({qv_b, q_b}), 32'({1'b1, 8'hA5}));
    step("sa0_idle", 0, 0, 0, 8'h00);
    check("sa0.qv_n2", 32'(qv_b), 32'd0);

    // Pointer wrap with single-word occupancy.
    for (int i = 0; i < 10; i++) begin
      step("wrap_wr", 0, 1, 0, 8'(i));
      check("wrap.cnt_le1", 32'(cnt_a <= 3'd1), 32'd1);
      step("wrap_rd", 0, 0, 1, 8'h00);
    end

    // Asynchronous reset mid-fill with a registered read in flight.
    step("mid_wr1", 0, 1, 0, 8'h91);
    step("mid_wr2", 0, 1, 0, 8'h92);
    step("mid_rd", 0, 1, 1, 8'h93);
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.cnt", 32'(cnt_a), 32'd0);
    check("arst.empty", 32'(empty_a), 32'd1);
    check("arst.qv_b", 32'(qv_b), 32'd0);
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with live thresholds.
    for (int i = 0; i < 400; i++) begin
      af_lvl = 3'($urandom_range(0, 7));
      ae_lvl = 3'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
